// File: rtl/uart_reg_bridge_if.sv
// UART byte stream and register bus signals of the bridge.
// master = bridge side, slave = UART FIFOs plus register file.
interface uart_reg_bridge_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  uart_rx_ready;
  logic [7:0]            uart_rx_byte;
  logic                  uart_rx_read;
  logic                  uart_tx_fifo_full;
  logic                  uart_tx_start;
  logic [7:0]            uart_tx_data_in;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;
  logic                  err;
  logic                  busy;

  modport master (
    input  uart_rx_ready,
    input  uart_rx_byte,
    input  uart_tx_fifo_full,
    input  reg_rdata,
    output uart_rx_read,
    output uart_tx_start,
    output uart_tx_data_in,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    output err,
    output busy
  );

  modport slave (
    output uart_rx_ready,
    output uart_rx_byte,
    output uart_tx_fifo_full,
    output reg_rdata,
    input  uart_rx_read,
    input  uart_tx_start,
    input  uart_tx_data_in,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    input  err,
    input  busy
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// UART command bridge: 'R' addr -> data byte, 'W' addr data -> 'K'.
// Unknown command -> '?' plus err; stalled command -> err, no reply.
module uart_reg_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 500000
) (
  input logic             clk,
  input logic             rst,
  uart_reg_bridge_if.master bus
);
  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_BUS_RD,
    S_BUS_CAP,
    S_BUS_WR,
    S_RESP
  } state_t;

  localparam logic [23:0] LP_TMO_LAST = 24'(TIMEOUT - 1);
  localparam logic [7:0]  LP_CMD_R    = 8'h52;
  localparam logic [7:0]  LP_CMD_W    = 8'h57;
  localparam logic [7:0]  LP_ACK      = 8'h4B;
  localparam logic [7:0]  LP_NAK      = 8'h3F;

  state_t                r_state;
  state_t                w_state_n;
  logic                  r_rd;
  logic                  r_pend;
  logic                  r_is_w;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic [7:0]            r_resp;
  logic [23:0]           r_cnt;
  logic                  w_pop;
  logic                  w_err;
  logic                  w_cnt_en;
  logic                  w_bad;

  assign w_bad = (bus.uart_rx_byte != LP_CMD_R) &&
                 (bus.uart_rx_byte != LP_CMD_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CMD;
    else     r_state <= w_state_n;
  end

  // r_rd marks the pop cycle, r_pend the cycle the byte is valid
  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_err     = 1'b0;
    w_cnt_en  = 1'b0;
    unique case (r_state)
      S_CMD: begin
        if (r_pend) begin
          if (w_bad) begin
            w_state_n = S_RESP;
            w_err     = 1'b1;
          end else begin
            w_state_n = S_ADDR;
          end
        end else begin
          w_pop = bus.uart_rx_ready & ~r_rd;
        end
      end
      S_ADDR, S_DATA: begin
        if (r_pend) begin
          if (r_state == S_DATA) w_state_n = S_BUS_WR;
          else if (r_is_w)       w_state_n = S_DATA;
          else                   w_state_n = S_BUS_RD;
        end else if (!r_rd) begin
          if (bus.uart_rx_ready) begin
            w_pop = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
            if (r_cnt == LP_TMO_LAST) begin
              w_state_n = S_CMD;
              w_err     = 1'b1;
            end
          end
        end
      end
      S_BUS_RD:  w_state_n = S_BUS_CAP;
      S_BUS_CAP: w_state_n = S_RESP;
      S_BUS_WR:  w_state_n = S_RESP;
      S_RESP: begin
        if (!bus.uart_tx_fifo_full) w_state_n = S_CMD;
      end
      default:   w_state_n = S_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_pend  <= 1'b0;
      r_is_w  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_resp  <= '0;
      r_cnt   <= '0;
    end else begin
      r_rd   <= w_pop;
      r_pend <= r_rd;
      if (r_pend && r_state == S_CMD)
        r_is_w <= (bus.uart_rx_byte == LP_CMD_W);
      if (r_pend && r_state == S_ADDR)
        r_addr <= ADDR_WIDTH'(bus.uart_rx_byte);
      if (r_pend && r_state == S_DATA)
        r_wdata <= bus.uart_rx_byte;
      if (r_pend && r_state == S_CMD && w_bad)
        r_resp <= LP_NAK;
      else if (r_state == S_BUS_WR)
        r_resp <= LP_ACK;
      else if (r_state == S_BUS_CAP)
        r_resp <= bus.reg_rdata;
      if (w_state_n != r_state || r_pend)
        r_cnt <= '0;
      else if (w_cnt_en)
        r_cnt <= r_cnt + 24'd1;
    end
  end

  assign bus.uart_rx_read    = r_rd;
  assign bus.uart_tx_start   = (r_state == S_RESP) &
                               ~bus.uart_tx_fifo_full;
  assign bus.uart_tx_data_in = r_resp;
  assign bus.reg_addr        = r_addr;
  assign bus.reg_wdata       = r_wdata;
  assign bus.reg_we          = (r_state == S_BUS_WR);
  assign bus.reg_re          = (r_state == S_BUS_RD);
  assign bus.err             = w_err;
  assign bus.busy            = (r_state != S_CMD);
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed scoreboard bench for uart_reg_bridge (TIMEOUT=100).
// Models the UART RX FIFO and an 8-bit register file.
module tb_uart_reg_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reg_bridge_if #(.ADDR_WIDTH(8)) bus ();

  uart_reg_bridge #(
    .ADDR_WIDTH(8),
    .TIMEOUT   (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_we  = 0;
  int n_re  = 0;
  int n_err = 0;
  int n_tx  = 0;
  int n_rd  = 0;
  int err_cyc = 0;

  logic [7:0]  mem [256];
  logic [7:0]  rxq [$];
  logic [7:0]  txexp [$];
  logic [15:0] wrexp [$];
  int          rd_cycs [$];
  int          tx_cycs [$];
  logic [7:0]  rx_b;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART RX FIFO and register file responders
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    if (bus.uart_rx_read) begin
      if (rxq.size() != 0) begin
        rx_b = rxq.pop_front();
        bus.uart_rx_byte <= rx_b;
      end
      bus.uart_rx_ready <= (rxq.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we || bus.reg_re)
        check("we_re_excl", 32'(bus.reg_we & bus.reg_re), 32'd0);
      if (bus.reg_we) begin
        n_we++;
        check("wr_pending", 32'(wrexp.size() != 0), 32'd1);
        if (wrexp.size() != 0)
          check("wr_addr_data", 32'({bus.reg_addr, bus.reg_wdata}),
                32'(wrexp.pop_front()));
      end
      if (bus.reg_re) n_re++;
      if (bus.err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (bus.uart_rx_read) begin
        n_rd++;
        rd_cycs.push_back(cyc);
      end
      if (bus.uart_tx_start) begin
        n_tx++;
        tx_cycs.push_back(cyc);
        check("tx_pending", 32'(txexp.size() != 0), 32'd1);
        if (txexp.size() != 0)
          check("tx_data", 32'(bus.uart_tx_data_in),
                32'(txexp.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    bus.uart_rx_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((txexp.size() != 0 || bus.busy || rxq.size() != 0) && k < 300) begin
      tick(1);
      k++;
    end
    check({tag, "_idle"}, 32'(k < 300), 32'd1);
    tick(2);
  endtask

  task automatic check_reset_outs(input string tag);
    @(negedge clk);
    check(tag, 32'({bus.uart_rx_read, bus.uart_tx_start,
                    bus.uart_tx_data_in, bus.reg_addr, bus.reg_wdata,
                    bus.reg_we, bus.reg_re, bus.err, bus.busy}), 32'd0);
  endtask

  initial begin
    int we0, re0, e0, tx0, rd1, drop, k;
    bus.uart_rx_ready     = 1'b0;
    bus.uart_rx_byte      = 8'h00;
    bus.reg_rdata         = 8'h00;
    bus.uart_tx_fifo_full = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    rst = 1'b1;
    tick(3);
    check_reset_outs("reset_outputs");
    tick(1);
    rst = 1'b0;
    tick(2);

    // write 57 05 A5
    we0 = n_we;
    txexp.push_back(8'h4B);
    wrexp.push_back(16'h05A5);
    send(8'h57); send(8'h05); send(8'hA5);
    wait_idle("wr");
    check("wr_we_count", 32'(n_we - we0), 32'd1);
    check("wr_busy_after", 32'(bus.busy), 32'd0);
    check("wr_addr_hold", 32'(bus.reg_addr), 32'h05);
    check("wr_wdata_hold", 32'(bus.reg_wdata), 32'hA5);
    check("wr_mem", 32'(mem[5]), 32'hA5);

    // read 52 05, latency from first pop
    mem[5] = 8'hA5;
    re0 = n_re; tx0 = n_tx;
    rd_cycs.delete(); tx_cycs.delete();
    txexp.push_back(8'hA5);
    send(8'h52); send(8'h05);
    wait_idle("rd");
    check("rd_re_count", 32'(n_re - re0), 32'd1);
    check("rd_tx_count", 32'(n_tx - tx0), 32'd1);
    check("rd_addr", 32'(bus.reg_addr), 32'h05);
    if (rd_cycs.size() != 0 && tx_cycs.size() != 0)
      check("rd_latency_le8", 32'((tx_cycs[0] - rd_cycs[0]) <= 8), 32'd1);
    else
      check("rd_latency_seen", 32'(rd_cycs.size() * tx_cycs.size()), 32'd1);

    // bad command then a normal read
    e0 = n_err; we0 = n_we; re0 = n_re;
    txexp.push_back(8'h3F);
    send(8'h13);
    wait_idle("bad");
    check("bad_err_count", 32'(n_err - e0), 32'd1);
    check("bad_no_we", 32'(n_we - we0), 32'd0);
    check("bad_no_re", 32'(n_re - re0), 32'd0);
    mem[0] = 8'h3C;
    re0 = n_re;
    txexp.push_back(8'h3C);
    send(8'h52); send(8'h00);
    wait_idle("bad_next");
    check("bad_next_re", 32'(n_re - re0), 32'd1);

    // timeout after 57 05
    e0 = n_err; tx0 = n_tx; we0 = n_we;
    rd_cycs.delete();
    send(8'h57); send(8'h05);
    k = 0;
    while (n_err == e0 && k < 400) begin
      tick(1);
      k++;
    end
    check("tmo_fired", 32'(n_err - e0), 32'd1);
    if (rd_cycs.size() >= 2)
      check("tmo_delay", 32'((err_cyc - rd_cycs[1]) >= 99 &&
                             (err_cyc - rd_cycs[1]) <= 103), 32'd1);
    else
      check("tmo_pops", 32'(rd_cycs.size()), 32'd2);
    tick(1);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_no_tx", 32'(n_tx - tx0), 32'd0);
    check("tmo_no_we", 32'(n_we - we0), 32'd0);
    txexp.push_back(8'hA5);
    send(8'h52); send(8'h05);
    wait_idle("tmo_next");

    // backpressure on the response
    bus.uart_tx_fifo_full = 1'b1;
    tx0 = n_tx;
    tx_cycs.delete();
    txexp.push_back(8'hA5);
    txexp.push_back(8'hA5);
    send(8'h52); send(8'h05);
    tick(12);
    send(8'h52); send(8'h05);
    rd1 = n_rd;
    tick(50);
    check("bp_no_tx", 32'(n_tx - tx0), 32'd0);
    check("bp_no_pop", 32'(n_rd - rd1), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'd1);
    bus.uart_tx_fifo_full = 1'b0;
    drop = cyc;
    wait_idle("bp");
    check("bp_tx_count", 32'(n_tx - tx0), 32'd2);
    if (tx_cycs.size() != 0)
      check("bp_release", 32'((tx_cycs[0] - drop) <= 1), 32'd1);

    // reset in the middle of a write
    we0 = n_we; tx0 = n_tx;
    send(8'h57); send(8'h05);
    tick(10);
    rst = 1'b1;
    check_reset_outs("rst_mid_outputs");
    tick(3);
    rst = 1'b0;
    e0 = n_err;
    tick(1);
    txexp.push_back(8'h3F);
    send(8'hA5);
    wait_idle("rst_mid");
    check("rst_mid_err", 32'(n_err - e0), 32'd1);
    check("rst_mid_no_we", 32'(n_we - we0), 32'd0);
    check("rst_mid_tx", 32'(n_tx - tx0), 32'd1);
    check("final_tx_drained", 32'(txexp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the register bus address; command address byte is zero-extended or truncated to ADDR_WIDTH.
REQ-002 Parameter TIMEOUT, default 500000, inter-byte timeout in clk cycles, legal range 2..2^24-1.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 uart_rx_ready  in  1  uart RX byte available.
REQ-006 uart_rx_byte  in  8  uart RX byte, valid the cycle after the uart_rx_read pulse.
REQ-007 uart_rx_read  out  1  one-cycle pop of one RX byte.
REQ-008 uart_tx_fifo_full  in  1  uart TX FIFO cannot accept.
REQ-009 uart_tx_start  out  1  one-cycle push of uart_tx_data_in into TX FIFO.
REQ-010 uart_tx_data_in  out  8  response byte.
REQ-011 reg_addr  out  ADDR_WIDTH  register bus address.
REQ-012 reg_wdata  out  8  register write data.
REQ-013 reg_we  out  1  one-cycle write strobe.
REQ-014 reg_re  out  1  one-cycle read strobe.
REQ-015 reg_rdata  in  8  read data, valid exactly one cycle after reg_re.
REQ-016 err  out  1  one-cycle pulse on protocol error or timeout.
REQ-017 busy  out  1  high whenever state is not CMD.

Function
REQ-018 Protocol: 0x52 ('R'), addr -> reply one byte reg[addr]; 0x57 ('W'), addr, data -> write, reply 0x4B ('K'); any other command byte -> reply 0x3F ('?') plus err pulse.
REQ-019 States: CMD, ADDR, DATA, BUS_RD, BUS_CAP, BUS_WR, RESP.
REQ-020 Byte fetch in CMD/ADDR/DATA: when uart_rx_ready=1 and no pop outstanding, pulse uart_rx_read one cycle; capture uart_rx_byte on the following cycle; no second pop until capture done.
REQ-021 CMD: captured 0x52 or 0x57 -> ADDR; other -> RESP with 0x3F, err=1 that cycle.
REQ-022 ADDR: capture into reg_addr; R -> BUS_RD, W -> DATA.
REQ-023 DATA: capture into reg_wdata -> BUS_WR.
REQ-024 BUS_WR: reg_we=1 one cycle, response 0x4B -> RESP.
REQ-025 BUS_RD: reg_re=1 one cycle -> BUS_CAP; BUS_CAP: latch reg_rdata as response -> RESP.
REQ-026 RESP: while uart_tx_fifo_full=1 hold; first cycle full=0 pulse uart_tx_start with response byte -> CMD.
REQ-027 reg_addr/reg_wdata held stable from capture until next capture.
REQ-028 Timeout counter clears on every captured byte and on entry to ADDR/DATA; counts only in ADDR/DATA while no pop outstanding; reaching TIMEOUT -> CMD, err=1 one cycle, no response, no bus strobe.
REQ-029 uart_rx_ready ignored in BUS_*/RESP; no RX pops there.
REQ-030 reg_we and reg_re never high in the same cycle; each at most one pulse per command.
REQ-031 A pop outstanding when timeout would fire completes capture first; that byte resets the counter.
REQ-032 Throughput: R command with empty FIFOs, ready always high: first uart_tx_start no later than 8 cycles after first uart_rx_read.

Reset
REQ-033 rst=1 forces state CMD, all outputs 0 (uart_rx_read, uart_tx_start, uart_tx_data_in, reg_addr, reg_wdata, reg_we, reg_re, err, busy), timeout counter 0.
REQ-034 rst asserted mid-command aborts it; no further strobe or response for that command after rst deasserts.

Verification
REQ-035 Write: RX bytes 57 05 A5 -> reg_we one cycle with reg_addr=05, reg_wdata=A5; TX byte 4B; busy low after.
REQ-036 Read: bench memory reg[05]=A5; RX 52 05 -> reg_re one cycle, addr 05; TX byte A5 exactly once.
REQ-037 Bad command: RX 13 -> err one cycle, TX 3F, no reg_we/reg_re; next RX 52 00 decodes normally.
REQ-038 Timeout (TIMEOUT=100): RX 57 05, no more bytes -> err pulse 100+/-2 cycles after addr capture, state CMD, no TX; then RX 52 05 answered correctly.
REQ-039 Backpressure: uart_tx_fifo_full=1 for 50 cycles during RESP -> uart_tx_start stays 0, fires one cycle after full drops, data unchanged; RX bytes waiting are not popped meanwhile.
REQ-040 Reset mid-command: RX 57 05, assert rst 3 cycles, release, send A5 -> treated as command byte: TX 3F, err pulse, no reg_we.
